// File: rtl/seq_adder_32bit.sv
// Two-pass 32-bit adder/subtractor sharing one 16-bit carry-lookahead adder.
// Define SEQ_ADDER_FLAGS_EN to build the ovf/zero flag logic; otherwise those outputs are tied to 0.
`timescale 1ns/1ps
module seq_adder_32bit (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        sub,
  input  logic        c_in,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] sum,
  output logic        c_out,
  output logic        ovf,
  output logic        zero
);

  localparam int DATA_W = 32;
  localparam int HALF_W = DATA_W / 2;

  typedef enum logic [1:0] {IDLE, LO, HI, DONE} state_t;

  state_t                    r_state;
  logic                      r_in_ready;
  logic                      r_out_valid;
  logic signed [DATA_W-1:0]  r_a;
  logic signed [DATA_W-1:0]  r_b;
  logic                      r_carry;
  logic        [HALF_W-1:0]  r_lo;
  logic        [DATA_W-1:0]  r_sum;
  logic                      r_cout;

  logic [HALF_W-1:0] w_add_a;
  logic [HALF_W-1:0] w_add_b;
  logic [HALF_W:0]   w_add;

  // 16-bit adder built from four 4-bit lookahead groups with group-level carry lookahead
  function automatic logic [HALF_W:0] cla16(input logic [HALF_W-1:0] a,
                                             input logic [HALF_W-1:0] b,
                                             input logic ci);
    logic [HALF_W-1:0] g;
    logic [HALF_W-1:0] p;
    logic [HALF_W-1:0] s;
    logic [4:0]        gc;
    logic [3:0]        gg;
    logic [3:0]        pp;
    logic [3:0]        c;
    g     = a & b;
    p     = a ^ b;
    s     = '0;
    gc    = '0;
    gc[0] = ci;
    for (int k = 0; k < 4; k++) begin
      gg   = g[4*k +: 4];
      pp   = p[4*k +: 4];
      c[0] = gc[k];
      c[1] = gg[0] | (pp[0] & c[0]);
      c[2] = gg[1] | (pp[1] & gg[0]) | (pp[1] & pp[0] & c[0]);
      c[3] = gg[2] | (pp[2] & gg[1]) | (pp[2] & pp[1] & gg[0]) | (pp[2] & pp[1] & pp[0] & c[0]);
      gc[k+1] = gg[3] | (pp[3] & gg[2]) | (pp[3] & pp[2] & gg[1]) |
                (pp[3] & pp[2] & pp[1] & gg[0]) | ((&pp) & c[0]);
      s[4*k +: 4] = pp ^ c;
    end
    return {gc[4], s};
  endfunction

  // r_carry holds the seed during LO and the low-half carry during HI
  always_comb begin
    w_add_a = r_a[HALF_W-1:0];
    w_add_b = r_b[HALF_W-1:0];
    if (r_state == HI) begin
      w_add_a = r_a[DATA_W-1:HALF_W];
      w_add_b = r_b[DATA_W-1:HALF_W];
    end
  end

  assign w_add = cla16(w_add_a, w_add_b, r_carry);

`ifdef SEQ_ADDER_FLAGS_EN
  logic r_ovf;
  logic r_zero;
  logic w_ovf_nxt;
  logic w_zero_nxt;

  assign w_ovf_nxt  = (r_a[DATA_W-1] == r_b[DATA_W-1]) && (w_add[HALF_W-1] != r_a[DATA_W-1]);
  assign w_zero_nxt = ~|{w_add[HALF_W-1:0], r_lo};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ovf  <= 1'b0;
      r_zero <= 1'b0;
    end else if (r_state == HI) begin
      r_ovf  <= w_ovf_nxt;
      r_zero <= w_zero_nxt;
    end
  end

  assign ovf  = r_ovf;
  assign zero = r_zero;
`else
  assign ovf  = 1'b0;
  assign zero = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state     <= IDLE;
      r_in_ready  <= 1'b1;
      r_out_valid <= 1'b0;
      r_a         <= '0;
      r_b         <= '0;
      r_carry     <= 1'b0;
      r_lo        <= '0;
      r_sum       <= '0;
      r_cout      <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (in_valid) begin
            r_a        <= op_a;
            r_b        <= op_b ^ {DATA_W{sub}};
            r_carry    <= sub | c_in;
            r_in_ready <= 1'b0;
            r_state    <= LO;
          end
        end
        // stage boundary: low half result and its carry
        LO: begin
          r_lo    <= w_add[HALF_W-1:0];
          r_carry <= w_add[HALF_W];
          r_state <= HI;
        end
        // stage boundary: full result becomes visible only here, so the previous one is held until now
        HI: begin
          r_sum       <= {w_add[HALF_W-1:0], r_lo};
          r_cout      <= w_add[HALF_W];
          r_out_valid <= 1'b1;
          r_state     <= DONE;
        end
        DONE: begin
          if (out_ready) begin
            r_out_valid <= 1'b0;
            r_in_ready  <= 1'b1;
            r_state     <= IDLE;
          end
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  assign in_ready  = r_in_ready;
  assign out_valid = r_out_valid;
  assign sum       = r_sum;
  assign c_out     = r_cout;

endmodule

// File: doc/seq_adder_32bit.md
SEQ_ADDER_32BIT -- requirements
Module: seq_adder_32bit

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset: `clk` (rising edge) and `rst` (asynchronous, active-high).
REQ-002 Ports SHALL be:
- `clk`  in  1  system clock
- `rst`  in  1  async active-high reset
- `in_valid`  in  1  operand set offered
- `in_ready`  out  1  block can accept operands
- `op_a`  in  32  addend A
- `op_b`  in  32  addend B
- `sub`  in  1  1 = A-B, 0 = A+B
- `c_in`  in  1  carry-in; used only when sub=0
- `out_valid`  out  1  result available
- `out_ready`  in  1  consumer takes result
- `sum`  out  32  result
- `c_out`  out  1  carry out of bit 31
- `ovf`  out  1  signed overflow
- `zero`  out  1  sum == 0

Function
REQ-003 The block SHALL compute 32-bit add/sub in two passes through a single shared 16-bit carry-lookahead adder: low half, then high half.
REQ-004 FSM states SHALL be IDLE, LO, HI and DONE.
REQ-005 In IDLE, in_ready SHALL be 1. In every other state, in_ready SHALL be 0.
REQ-006 At an edge in IDLE with in_valid=1, the block SHALL:
- register op_a;
- register op_b XOR {32{sub}};
- register the carry seed as (sub ? 1 : c_in);
- go to LO.
REQ-007 In LO, the adder SHALL add the low halves with the carry seed. At the next edge the block SHALL register sum[15:0] and the low carry, then go to HI.
REQ-008 In HI, the adder SHALL add the high halves with the registered low carry. At the next edge the block SHALL register sum[31:16], c_out, ovf and zero, then go to DONE.
REQ-009 ovf SHALL equal (A[31] == B'[31]) AND (sum[31] != A[31]), where B' is the registered (possibly inverted) operand.
REQ-010 zero SHALL be 1 iff all 32 sum bits are 0.
REQ-011 In DONE, out_valid SHALL be 1. sum, c_out, ovf and zero SHALL be held stable until out_ready=1.
REQ-012 At an edge in DONE with out_ready=1, the block SHALL go to IDLE and deassert out_valid.
REQ-013 Latency SHALL be 3 edges: out_valid rises in the cycle after the third rising edge counted from the accepting edge. Minimum issue interval SHALL be 4 cycles.
REQ-014 in_valid outside IDLE SHALL be ignored. Operand inputs need not be held after acceptance.
REQ-015 out_ready outside DONE SHALL be ignored. out_ready held high SHALL NOT shorten latency.
REQ-016 Arithmetic SHALL wrap modulo 2^32.
REQ-017 For subtraction, c_out=1 SHALL mean no borrow (A >= B unsigned).
REQ-018 Result outputs SHALL retain their last value after the handshake until overwritten by the next HI edge.

Reset
REQ-019 While rst=1, asynchronously:
- state SHALL be IDLE;
- in_ready SHALL be 1;
- out_valid, sum, c_out, ovf and zero SHALL be 0;
- all internal operand and carry registers SHALL be 0.
REQ-020 Reset asserted in LO, HI or DONE SHALL discard the operation; no out_valid SHALL follow it.
REQ-021 After rst deasserts, the first rising edge SHALL already be able to accept operands.

Configuration
REQ-022 With macro SEQ_ADDER_FLAGS_EN defined, ovf and zero SHALL behave per REQ-009 and REQ-010.
REQ-023 Without SEQ_ADDER_FLAGS_EN, ovf and zero SHALL be tied to 0 and their registers and logic SHALL be absent. sum, c_out and timing SHALL be unchanged.

Verification
REQ-024 op_a=0x0000FFFF, op_b=0x00000001, sub=0, c_in=0 -> sum=0x00010000, c_out=0, ovf=0, zero=0. This checks the low-to-high carry pass.
REQ-025 op_a=0xFFFFFFFF, op_b=0x00000001, sub=0, c_in=0 -> sum=0x00000000, c_out=1, zero=1, ovf=0.
REQ-026 op_a=0x7FFFFFFF, op_b=0xFFFFFFFF, sub=1 -> sum=0x80000000, ovf=1, c_out=0. Also op_a=5, op_b=5, sub=1 -> sum=0, zero=1, c_out=1.
REQ-027 Backpressure: hold out_ready=0 for 5 cycles in DONE -> out_valid and sum stay stable and in_ready stays 0. Pulse out_ready -> IDLE next edge.
REQ-028 Assert rst during HI -> outputs read 0 immediately. A new operation issued after reset completes correctly and no stale out_valid appears.
REQ-029 Build without SEQ_ADDER_FLAGS_EN and rerun REQ-026 -> sum and c_out are identical, and ovf=zero=0.
